// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx among NUM_REQ byte sources.
// Build option: define UART_ARB_LOCK_EN to add req_lock for multi-byte atomic messages.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req_valid[i]      requester i has a byte pending (held until accepted)
//   req_data          byte of requester i in bits [8*i+7:8*i]
//   req_ready[i]      combinational one-hot accept, only in IDLE
//   req_lock[i]       (UART_ARB_LOCK_EN only) keep the grant after this byte
//   tx_data, tx_send  registered byte and one-cycle start pulse to uart_tx
//   tx_busy           uart_tx busy
//   grant_id          index of the last accepted requester
//   active            state is not IDLE
//   err_no_busy       one-cycle pulse when tx_busy never rose after tx_send
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BUSY_WAIT = 4,
    localparam int IDW      = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   req_lock,
`endif
    output logic [7:0]           tx_data,
    output logic                 tx_send,
    input  logic                 tx_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 active,
    output logic                 err_no_busy
);

    localparam int CW = $clog2(BUSY_WAIT) + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEND    = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_send_q, tx_send_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic [IDW-1:0]     last_q, last_d;
    logic               err_q, err_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [NUM_REQ-1:0] elig;
    logic [IDW-1:0]     win;
    logic [IDW-1:0]     cand;
    logic               win_found;
    logic               accept;

`ifdef UART_ARB_LOCK_EN
    logic               lock_q, lock_d;
    logic [IDW-1:0]     lock_id_q, lock_id_d;
`endif

    // While a lock is held only the locking requester is eligible.
    always_comb begin
        elig = req_valid;
`ifdef UART_ARB_LOCK_EN
        if (lock_q) begin
            elig = '0;
            elig[lock_id_q] = req_valid[lock_id_q];
        end
`endif
    end

    // Scan last+1, last+2, ... so the previous winner has lowest priority.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(last_q) + k) % NUM_REQ);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end
    end

    assign accept    = (state_q == ST_IDLE) && !tx_busy && win_found;
    assign req_ready = accept ? (NUM_REQ'(1) << win) : '0;

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_send_d  = 1'b0;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
`ifdef UART_ARB_LOCK_EN
        lock_d     = lock_q;
        lock_id_d  = lock_id_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tx_data_d  = req_data[{win, 3'b000} +: 8];
                    tx_send_d  = 1'b1;
                    grant_id_d = win;
                    state_d    = ST_SEND;
`ifdef UART_ARB_LOCK_EN
                    lock_d     = req_lock[win];
                    lock_id_d  = win;
                    // Rotation advances only once the message is complete.
                    last_d     = req_lock[win] ? last_q : win;
`else
                    last_d     = win;
`endif
                end
            end
            ST_SEND: begin
                cnt_d   = '0;
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_LO;
                end else if (cnt_q == CW'(BUSY_WAIT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= '0;
            tx_send_q  <= 1'b0;
            grant_id_q <= '0;
            last_q     <= IDW'(NUM_REQ - 1);
            err_q      <= 1'b0;
            cnt_q      <= '0;
`ifdef UART_ARB_LOCK_EN
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_send_q  <= tx_send_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
`ifdef UART_ARB_LOCK_EN
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
`endif
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_send     = tx_send_q;
    assign grant_id    = grant_id_q;
    assign active      = (state_q != ST_IDLE);
    assign err_no_busy = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with a uart_tx busy stub.
// Expected bytes are queued in send order and checked against every tx_send.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int BW    = 4;
    localparam int FRAME = 20;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_send;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           active;
    logic           err_no_busy;
`ifdef UART_ARB_LOCK_EN
    logic [N-1:0]   req_lock;
`endif

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_WAIT(BW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
`ifdef UART_ARB_LOCK_EN
        .req_lock    (req_lock),
`endif
        .tx_data     (tx_data),
        .tx_send     (tx_send),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .err_no_busy (err_no_busy)
    );

    always #5 clk = ~clk;

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] exp_q[$];
    int         busy_cnt;
    logic       force_busy;
    logic       stub_on;
    int         cyc = 0;
    int         send_cyc;
    int         err_cyc;
    int         acc_cnt[N];
    logic [N-1:0] acc;

    // One clock: capture accepts, drop accepted valids after the edge,
    // then at the falling edge run the scoreboard and the busy stub.
    task automatic tick();
        logic [7:0] e;
        #1;
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
        for (int i = 0; i < N; i++) acc_cnt[i] += int'(acc[i]);
        @(negedge clk);
        cyc++;
        if (busy_cnt > 0) busy_cnt--;
        if (!rst && tx_send) begin
            send_cyc = cyc;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: got byte %h, required no send", tx_data);
            end else begin
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    tests_failed++;
                    $display("FAIL sb_byte: got %h, required %h", tx_data, e);
                end
            end
            if (stub_on) busy_cnt = FRAME;
        end
        if (!rst && err_no_busy) err_cyc = cyc;
        tx_busy = force_busy | (busy_cnt != 0);
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
`ifdef UART_ARB_LOCK_EN
        req_lock   = '0;
`endif
        force_busy = 1'b0;
        stub_on    = 1'b1;
        busy_cnt   = 0;
        tx_busy    = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_until_idle(input int bound, input string name);
        bit done;
        done = 0;
        for (int i = 0; i < bound && !done; i++) begin
            tick();
            if (req_valid == '0 && !active && !tx_busy) done = 1;
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL %s_timeout: active=%b valid=%b, required idle", name, active, req_valid);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_sb_left: %0d bytes pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rst_ready: got %b, required 0000", req_ready);
        end
        tests_run++;
        if (tx_send !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_send: got %b, required 0", tx_send);
        end
        tests_run++;
        if (tx_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL rst_data: got %h, required 00", tx_data);
        end
        tests_run++;
        if (grant_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL rst_grant: got %0d, required 0", grant_id);
        end
        tests_run++;
        if (active !== 1'b0 || err_no_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_flags: active=%b err=%b, required 0 0", active, err_no_busy);
        end
    endtask

    task automatic test_single();
        req_valid[0]   = 1'b1;
        req_data[7:0]  = 8'hA5;
        exp_q.push_back(8'hA5);
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_ready: got %b, required 0001", req_ready);
        end
        tick();
        tests_run++;
        if (tx_send !== 1'b1 || active !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_latency: send=%b active=%b, required 1 1", tx_send, active);
        end
        tests_run++;
        if (grant_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL single_grant: got %0d, required 0", grant_id);
        end
        tick();
        tests_run++;
        if (tx_send !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_pulse: send=%b, required 0", tx_send);
        end
        run_until_idle(100, "single");
    endtask

    task automatic test_all_four();
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            req_valid = 4'b1111;
            req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
            exp_q.push_back(8'h10);
            exp_q.push_back(8'h21);
            exp_q.push_back(8'h32);
            exp_q.push_back(8'h43);
            #1;
            tests_run++;
            if (req_ready !== 4'b0001) begin
                tests_failed++;
                $display("FAIL all_first_ready round %0d: got %b, required 0001", r, req_ready);
            end
            run_until_idle(400, "all_four");
            tests_run++;
            if (grant_id !== 2'd3) begin
                tests_failed++;
                $display("FAIL all_last_grant: got %0d, required 3", grant_id);
            end
        end
    endtask

    task automatic test_fairness();
        bit r2;
        bit done;
        apply_reset();
        r2   = 0;
        done = 0;
        req_data[7:0]   = 8'h55;
        req_data[23:16] = 8'h77;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h55);
        for (int i = 0; i < 300 && !done; i++) begin
            if (acc_cnt[0] < 2) req_valid[0] = 1'b1;
            if (tx_busy && !r2) begin
                req_valid[2] = 1'b1;
                r2 = 1;
            end
            tick();
            if (acc_cnt[0] == 2 && acc_cnt[2] == 1 && !active && !tx_busy)
                done = 1;
        end
        tests_run++;
        if (!done || acc_cnt[2] != 1) begin
            tests_failed++;
            $display("FAIL fair_done: req2 grants=%0d, required 1", acc_cnt[2]);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL fair_sb_left: %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_no_busy();
        apply_reset();
        stub_on  = 1'b0;
        send_cyc = -1;
        err_cyc  = -1;
        req_valid[1]   = 1'b1;
        req_data[15:8] = 8'h3C;
        exp_q.push_back(8'h3C);
        for (int i = 0; i < 50 && err_cyc < 0; i++) tick();
        tests_run++;
        if (err_cyc - send_cyc !== BW + 1 || send_cyc < 0) begin
            tests_failed++;
            $display("FAIL nobusy_delay: got %0d, required %0d", err_cyc - send_cyc, BW + 1);
        end
        tests_run++;
        if (active !== 1'b0 || err_no_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL nobusy_idle: active=%b err=%b, required 0 1", active, err_no_busy);
        end
        stub_on = 1'b1;
        req_valid[2]    = 1'b1;
        req_data[23:16] = 8'h5A;
        exp_q.push_back(8'h5A);
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL nobusy_regrant: got %b, required 0100", req_ready);
        end
        tick();
        tests_run++;
        if (err_no_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL nobusy_pulse: err=%b, required 0", err_no_busy);
        end
        run_until_idle(100, "nobusy");
    endtask

    task automatic test_ext_busy_reset();
        apply_reset();
        force_busy = 1'b1;
        tx_busy    = 1'b1;
        req_valid[1]   = 1'b1;
        req_data[15:8] = 8'h66;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (req_ready !== 4'b0000 || active !== 1'b0) begin
                tests_failed++;
                $display("FAIL extbusy_hold: ready=%b active=%b, required 0000 0", req_ready, active);
            end
        end
        force_busy = 1'b0;
        tx_busy    = 1'b0;
        exp_q.push_back(8'h66);
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL extbusy_release: got %b, required 0010", req_ready);
        end
        run_until_idle(100, "extbusy");

        req_valid[3]    = 1'b1;
        req_data[31:24] = 8'h99;
        exp_q.push_back(8'h99);
        tick();
        tick();
        tick();
        tick();
        tests_run++;
        if (active !== 1'b1 || tx_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_pre: active=%b busy=%b, required 1 1", active, tx_busy);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (active !== 1'b0 || tx_send !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_state: active=%b send=%b, required 0 0", active, tx_send);
        end
        tests_run++;
        if (tx_data !== 8'h00 || grant_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL midrst_regs: data=%h grant=%0d, required 00 0", tx_data, grant_id);
        end
        rst      = 1'b0;
        busy_cnt = 0;
        tx_busy  = 1'b0;
        req_valid       = 4'b0110;
        req_data[15:8]  = 8'h11;
        req_data[23:16] = 8'h22;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL midrst_ptr: got %b, required 0010", req_ready);
        end
        run_until_idle(200, "midrst");
    endtask

`ifdef UART_ARB_LOCK_EN
    task automatic test_lock();
        logic [7:0] lb[3];
        logic       ll[3];
        bit         done;
        lb = '{8'h41, 8'h42, 8'h43};
        ll = '{1'b1, 1'b1, 1'b0};
        apply_reset();
        done = 0;
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        exp_q.push_back(8'h30);
        for (int i = 0; i < 400 && !done; i++) begin
            if (!req_valid[1] && acc_cnt[1] < 3) begin
                req_valid[1]   = 1'b1;
                req_data[15:8] = lb[acc_cnt[1]];
                req_lock[1]    = ll[acc_cnt[1]];
            end
            if (acc_cnt[1] >= 1 && acc_cnt[0] == 0) begin
                req_valid[0]  = 1'b1;
                req_data[7:0] = 8'h30;
            end
            tick();
            if (acc_cnt[0] == 1 && !active && !tx_busy) done = 1;
        end
        tests_run++;
        if (!done || acc_cnt[1] != 3) begin
            tests_failed++;
            $display("FAIL lock_done: req1 grants=%0d, required 3", acc_cnt[1]);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL lock_sb_left: %0d pending, required 0", exp_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_no_busy();
        test_ext_busy_reset();
`ifdef UART_ARB_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
